// File: rtl/dma_ch_sched.sv
`default_nettype none
// ============================================================================
// Module   : dma_ch_sched
// Purpose  : Channel scheduler for the AHB DMA. Picks one enabled, requesting
//            channel (high-priority level first, round-robin inside each
//            level). For that channel it sequences one read burst and then
//            one write burst on the single AHB master engine. It returns
//            one-cycle read/write acknowledges or an error pulse to the
//            peripheral request mux.
// Ports    : clk_i, rst_i          clock, synchronous active-high reset
//            dma_en_i             global enable, gates new grants only
//            ch_en_i/ch_hprio_i   per-channel enable / high-priority flag
//            ch_len_i             per-channel burst length (beats-1)
//            ch_rreq_i/ch_wreq_i  source / destination ready from mux
//            ch_rack_o/ch_wack_o  read / write burst done pulses
//            ch_err_o             bus error or write-wait abort pulse
//            eng_*                burst request/response to AHB engine
//            busy_o, act_ch_o     scheduler status
// Revision : 1.0 - initial release
// ============================================================================
module dma_ch_sched #(
  parameter int CHANNEL_NUM = 8,
  parameter int LEN_W       = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                dma_en_i,
  input  logic [CHANNEL_NUM-1:0]              ch_en_i,
  input  logic [CHANNEL_NUM-1:0]              ch_hprio_i,
  input  logic [CHANNEL_NUM-1:0][LEN_W-1:0]   ch_len_i,
  input  logic [CHANNEL_NUM-1:0]              ch_rreq_i,
  input  logic [CHANNEL_NUM-1:0]              ch_wreq_i,
  output logic [CHANNEL_NUM-1:0]              ch_rack_o,
  output logic [CHANNEL_NUM-1:0]              ch_wack_o,
  output logic [CHANNEL_NUM-1:0]              ch_err_o,
  output logic                                eng_req_o,
  output logic                                eng_dir_o,
  output logic [$clog2(CHANNEL_NUM)-1:0]      eng_ch_o,
  output logic [LEN_W-1:0]                    eng_len_o,
  input  logic                                eng_beat_i,
  input  logic                                eng_err_i,
  output logic                                busy_o,
  output logic [$clog2(CHANNEL_NUM)-1:0]      act_ch_o
);

  localparam int c_CH_W = $clog2(CHANNEL_NUM);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_RD      = 3'd1;
  localparam logic [2:0] c_ST_WR_WAIT = 3'd2;
  localparam logic [2:0] c_ST_WR      = 3'd3;
  localparam logic [2:0] c_ST_DONE    = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]             r_state;
  logic [c_CH_W-1:0]      r_rr_ptr;
  logic [c_CH_W-1:0]      r_act_ch;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_beat_cnt;
  logic [CHANNEL_NUM-1:0] r_rack;
  logic [CHANNEL_NUM-1:0] r_wack;
  logic [CHANNEL_NUM-1:0] r_err;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [CHANNEL_NUM-1:0] w_elig;
  logic [CHANNEL_NUM-1:0] w_hi;
  logic [CHANNEL_NUM-1:0] w_lo;
  logic [CHANNEL_NUM-1:0] w_cand;
  logic [c_CH_W:0]        w_idx;
  logic [c_CH_W-1:0]      w_sel;
  logic [c_CH_W-1:0]      w_rr_next;
  logic                   w_grant;

  assign w_elig  = ch_en_i & ch_rreq_i;
  assign w_hi    = w_elig & ch_hprio_i;
  assign w_lo    = w_elig & ~ch_hprio_i;
  // The low level is only considered when no high-priority channel is eligible.
  assign w_cand  = (|w_hi) ? w_hi : w_lo;
  assign w_grant = dma_en_i && (|w_elig);

  // Round-robin search starting at r_rr_ptr and wrapping upward. The loop runs
  // from the farthest offset down to offset 0, so the last hit written is the
  // candidate closest to the pointer.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rr_ptr} + (c_CH_W + 1)'(i);
      if (w_idx >= (c_CH_W + 1)'(CHANNEL_NUM)) begin
        w_idx = w_idx - (c_CH_W + 1)'(CHANNEL_NUM);
      end
      if (w_cand[w_idx[c_CH_W-1:0]]) begin
        w_sel = w_idx[c_CH_W-1:0];
      end
    end
  end

  assign w_rr_next = (w_sel == c_CH_W'(CHANNEL_NUM - 1)) ? '0 : (w_sel + c_CH_W'(1));

  // --------------------------------------------------------------------------
  // Burst sequencing
  // --------------------------------------------------------------------------
  logic [CHANNEL_NUM-1:0] w_act_oh;
  logic                   w_last;

  assign w_act_oh = {{(CHANNEL_NUM-1){1'b0}}, 1'b1} << r_act_ch;
  // beat_cnt is compared before it increments, so len = all-ones still gives
  // the full 2^LEN_W beats without the counter wrapping early.
  assign w_last   = (r_beat_cnt == r_len);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= c_ST_IDLE;
      r_rr_ptr   <= '0;
      r_act_ch   <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_rack     <= '0;
      r_wack     <= '0;
      r_err      <= '0;
    end else begin
      // Acknowledge and error outputs are single-cycle pulses.
      r_rack <= '0;
      r_wack <= '0;
      r_err  <= '0;

      case (r_state)
        c_ST_IDLE: begin
          if (w_grant) begin
            r_act_ch   <= w_sel;
            r_len      <= ch_len_i[w_sel];
            r_rr_ptr   <= w_rr_next;
            r_beat_cnt <= '0;
            r_state    <= c_ST_RD;
          end
        end

        c_ST_RD, c_ST_WR: begin
          // A bus error wins over a coincident last beat: no ack is sent.
          if (eng_err_i) begin
            r_err      <= w_act_oh;
            r_beat_cnt <= '0;
            r_state    <= c_ST_IDLE;
          end else if (eng_beat_i) begin
            if (w_last) begin
              r_beat_cnt <= '0;
              if (r_state == c_ST_RD) begin
                r_rack  <= w_act_oh;
                r_state <= c_ST_WR_WAIT;
              end else begin
                r_wack  <= w_act_oh;
                r_state <= c_ST_DONE;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
          end
        end

        c_ST_WR_WAIT: begin
          // A channel disabled while waiting for its destination is aborted;
          // this takes precedence over a simultaneous write request.
          if (!ch_en_i[r_act_ch]) begin
            r_err   <= w_act_oh;
            r_state <= c_ST_IDLE;
          end else if (ch_wreq_i[r_act_ch]) begin
            r_state <= c_ST_WR;
          end
        end

        // One-cycle cooldown so the peripheral can drop its request before
        // the next arbitration.
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (registered or decoded from registered state only)
  // --------------------------------------------------------------------------
  assign ch_rack_o = r_rack;
  assign ch_wack_o = r_wack;
  assign ch_err_o  = r_err;
  assign eng_req_o = (r_state == c_ST_RD) || (r_state == c_ST_WR);
  assign eng_dir_o = (r_state == c_ST_WR);
  assign eng_ch_o  = r_act_ch;
  assign eng_len_o = r_len;
  assign busy_o    = (r_state != c_ST_IDLE);
  assign act_ch_o  = r_act_ch;

endmodule
`default_nettype wire
